// File: rtl/spi_slave_rx_tx.sv
// SPI slave endpoint: oversamples sck/ss/mosi on clk_i, deserialises MOSI into
// bytes on a valid/ready port and serialises transmit bytes onto MISO.
module spi_slave_rx_tx #(
  parameter logic [7:0] TX_DEFAULT  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       sck_i,
  input  logic       ss_ni,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       overrun_o,
  output logic       underrun_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, ss_sync_reg, mosi_sync_reg;
  logic [SYNC_STAGES-1:0] sck_sync_next, ss_sync_next, mosi_sync_next;
  logic                   sck_prev_reg, ss_prev_reg;
  logic                   cpol_reg, cpha_reg;
  logic [2:0]             bit_cnt_reg;
  logic [7:0]             rx_shift_reg, tx_shift_reg;
  logic                   miso_reg;
  logic                   byte_done_reg;
  logic [7:0]             rx_data_reg;
  logic                   rx_valid_reg;

  logic sck_s, ss_s, mosi_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;
  logic reload, busy, oe, tx_ready, underrun;
  logic [7:0] tx_load_byte;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sck_sync_next[gi]  = sck_i;
        assign ss_sync_next[gi]   = ss_ni;
        assign mosi_sync_next[gi] = mosi_i;
      end else begin : g_rest
        assign sck_sync_next[gi]  = sck_sync_reg[gi-1];
        assign ss_sync_next[gi]   = ss_sync_reg[gi-1];
        assign mosi_sync_next[gi] = mosi_sync_reg[gi-1];
      end
    end
  endgenerate

  assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
  assign ss_s   = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_edge   = (sck_prev_reg == cpol_reg) && (sck_s != cpol_reg);
  assign trail_edge  = (sck_prev_reg != cpol_reg) && (sck_s == cpol_reg);
  assign sample_edge = cpha_reg ? trail_edge : lead_edge;
  assign shift_edge  = cpha_reg ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev_reg && !ss_s;
  assign ss_rise     = !ss_prev_reg && ss_s;

  assign tx_load_byte = tx_valid_i ? tx_data_i : TX_DEFAULT;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    reload     = 1'b0;
    busy       = 1'b0;
    oe         = 1'b0;
    tx_ready   = 1'b0;
    underrun   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        reload     = 1'b1;
        state_next = ACTIVE;
      end
      ACTIVE: begin
        busy = 1'b1;
        oe   = 1'b1;
        if (ss_rise) begin
          state_next = IDLE;
        end else if (byte_done_reg) begin
          reload = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (reload) begin
      tx_ready = tx_valid_i;
      underrun = !tx_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sck_sync_reg  <= {SYNC_STAGES{cpol_i}};
      ss_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sck_prev_reg  <= cpol_i;
      ss_prev_reg   <= 1'b1;
      cpol_reg      <= cpol_i;
      cpha_reg      <= cpha_i;
      bit_cnt_reg   <= 3'd0;
      rx_shift_reg  <= 8'h00;
      tx_shift_reg  <= 8'h00;
      miso_reg      <= 1'b0;
      byte_done_reg <= 1'b0;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
    end else begin
      sck_sync_reg  <= sck_sync_next;
      ss_sync_reg   <= ss_sync_next;
      mosi_sync_reg <= mosi_sync_next;
      sck_prev_reg  <= sck_s;
      ss_prev_reg   <= ss_s;
      byte_done_reg <= 1'b0;

      if (state_reg == IDLE) begin
        cpol_reg <= cpol_i;
        cpha_reg <= cpha_i;
      end

      if (reload) begin
        tx_shift_reg <= tx_load_byte;
      end

      if (state_reg == LOAD) begin
        bit_cnt_reg <= 3'd0;
      end else if (state_reg == ACTIVE) begin
        if (ss_rise) begin
          bit_cnt_reg <= 3'd0;
        end else begin
          if (sample_edge) begin
            rx_shift_reg <= {rx_shift_reg[6:0], mosi_s};
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              byte_done_reg <= 1'b1;
            end
          end
          // With cpha=0 the trailing edge right after the 8th sample belongs
          // to the finished byte; the reloaded MSB must stay on the line.
          if (shift_edge && !reload) begin
            if (cpha_reg) begin
              miso_reg     <= tx_shift_reg[7];
              tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end else if (bit_cnt_reg != 3'd0) begin
              tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end
          end
        end
      end

      if (byte_done_reg && (!rx_valid_reg || rx_ready_i)) begin
        rx_data_reg  <= rx_shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_ready_i) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign miso_o     = (state_reg == ACTIVE) && (cpha_reg ? miso_reg : tx_shift_reg[7]);
  assign miso_oe_o  = oe;
  assign busy_o     = busy;
  assign tx_ready_o = tx_ready;
  assign underrun_o = underrun;
  assign overrun_o  = byte_done_reg && rx_valid_reg && !rx_ready_i;
  assign rx_data_o  = rx_data_reg;
  assign rx_valid_o = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: a behavioural SPI master plus tx/rx stream models.
module tb_spi_slave_rx_tx;

  logic       clk = 1'b0;
  logic       rst_i, cpol_i, cpha_i, sck_i, ss_ni, mosi_i;
  logic       miso_o, miso_oe_o, rx_valid_o, rx_ready_i;
  logic [7:0] rx_data_o, tx_data_i;
  logic       tx_valid_i, tx_ready_o, overrun_o, underrun_o, busy_o;

  always #5 clk = ~clk;

  spi_slave_rx_tx dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .sck_i      (sck_i),
    .ss_ni      (ss_ni),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .miso_oe_o  (miso_oe_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .overrun_o  (overrun_o),
    .underrun_o (underrun_o),
    .busy_o     (busy_o)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_tx [4];
  logic [7:0]  m_rx [4];
  logic        win_en = 1'b0;
  logic        busy_seen;
  logic [14:0] rst_snap;

  int         txr_cnt = 0, und_cnt = 0, ovr_cnt = 0;
  logic [7:0] rx_got [$];
  logic [7:0] tx_arr [64];
  int         tx_len  = 0;
  int         tx_idx  = 0;
  int         tx_mode = 0;   // 0 none, 1 hold tx_hold, 2 stream from tx_arr
  logic [7:0] tx_hold = 8'h00;
  logic       tx_took = 1'b0;

  function automatic logic [14:0] outs();
    return {miso_o, miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o, overrun_o, underrun_o, busy_o};
  endfunction

  // Transmit-source model and output monitors, updated once per cycle.
  initial begin : monitor
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_took && tx_mode == 2) tx_idx++;
      case (tx_mode)
        1: begin
          tx_valid_i = 1'b1;
          tx_data_i  = tx_hold;
        end
        2: begin
          tx_valid_i = (tx_idx < tx_len);
          tx_data_i  = (tx_idx < tx_len) ? tx_arr[tx_idx] : 8'h00;
        end
        default: begin
          tx_valid_i = 1'b0;
          tx_data_i  = 8'h00;
        end
      endcase
      #2;
      tx_took = tx_ready_o;
      if (win_en && tx_ready_o) txr_cnt++;
      if (win_en && underrun_o) und_cnt++;
      if (overrun_o) ovr_cnt++;
      if (rx_valid_o && rx_ready_i) rx_got.push_back(rx_data_o);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1, "timeout");
  end

  // SPI master, sck = clk/8. stop_bits > 0 cuts the frame after that many
  // bits, either by raising ss or (stop_rst) with a one-cycle reset.
  task automatic master_frame(input logic pol, input logic pha, input int nbytes,
                              input int stop_bits, input logic stop_rst);
    logic stop;
    logic last;
    int   bits;
    stop = 1'b0;
    bits = 0;
    busy_seen = 1'b0;
    @(negedge clk);
    cpol_i = pol; cpha_i = pha; sck_i = pol; ss_ni = 1'b1; mosi_i = 1'b0;
    repeat (6) @(negedge clk);
    ss_ni  = 1'b0;
    win_en = 1'b1;
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbytes && !stop; b++) begin
      for (int i = 7; i >= 0 && !stop; i--) begin
        last = (b == nbytes - 1) && (i == 0);
        if (pha) sck_i = ~pol;
        mosi_i = m_tx[b][i];
        repeat (4) @(negedge clk);
        m_rx[b][i] = miso_o;
        if (busy_o) busy_seen = 1'b1;
        if (last) win_en = 1'b0;
        sck_i = pha ? pol : ~pol;
        repeat (4) @(negedge clk);
        if (!pha) sck_i = pol;
        bits++;
        if (stop_bits > 0 && bits == stop_bits) stop = 1'b1;
      end
    end
    if (stop && stop_rst) begin
      rst_i = 1'b0;
      @(negedge clk);
      rst_snap = outs();
      rst_i  = 1'b1;
      ss_ni  = 1'b1;
      sck_i  = pol;
      win_en = 1'b0;
    end else begin
      repeat (4) @(negedge clk);
      ss_ni  = 1'b1;
      win_en = 1'b0;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (outs() !== 15'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=%h", outs(), 15'h0);
    end
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_o, miso_oe_o, rx_valid_o} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset got=%b required=000", {busy_o, miso_oe_o, rx_valid_o});
    end
  endtask

  task automatic test_mode0();
    int rb, tc;
    logic [7:0] g;
    tx_mode = 1; tx_hold = 8'h3C; rx_ready_i = 1'b1;
    rb = rx_got.size(); tc = txr_cnt;
    m_tx[0] = 8'hA5;
    master_frame(1'b0, 1'b0, 1, 0, 1'b0);
    g = (rx_got.size() > rb) ? rx_got[rb] : 8'hxx;
    $display("mode0: sent=%h rx=%h master_got=%h", m_tx[0], g, m_rx[0]);
    total++;
    if (rx_got.size() - rb !== 1) begin bad++; $display("FAIL mode0_rx_count got=%0d required=1", rx_got.size() - rb); end
    total++;
    if (g !== 8'hA5) begin bad++; $display("FAIL mode0_rx_data got=%h required=a5", g); end
    total++;
    if (m_rx[0] !== 8'h3C) begin bad++; $display("FAIL mode0_miso got=%h required=3c", m_rx[0]); end
    total++;
    if (txr_cnt - tc !== 1) begin bad++; $display("FAIL mode0_tx_ready got=%0d required=1", txr_cnt - tc); end
    total++;
    if ({busy_seen, busy_o, miso_oe_o} !== 3'b100) begin
      bad++;
      $display("FAIL mode0_busy got=%b required=100", {busy_seen, busy_o, miso_oe_o});
    end
  endtask

  task automatic test_mode3_two_bytes();
    int rb, tc;
    logic [7:0] g0, g1;
    tx_mode = 2; rx_ready_i = 1'b1;
    tx_arr[tx_len] = 8'hC3; tx_len++;
    tx_arr[tx_len] = 8'h5A; tx_len++;
    rb = rx_got.size(); tc = txr_cnt;
    m_tx[0] = 8'h12; m_tx[1] = 8'h34;
    master_frame(1'b1, 1'b1, 2, 0, 1'b0);
    g0 = (rx_got.size() > rb)     ? rx_got[rb]     : 8'hxx;
    g1 = (rx_got.size() > rb + 1) ? rx_got[rb + 1] : 8'hxx;
    $display("mode3: rx=%h,%h master_got=%h,%h", g0, g1, m_rx[0], m_rx[1]);
    total++;
    if (rx_got.size() - rb !== 2) begin bad++; $display("FAIL mode3_rx_count got=%0d required=2", rx_got.size() - rb); end
    total++;
    if ({g0, g1} !== 16'h1234) begin bad++; $display("FAIL mode3_rx_data got=%h required=1234", {g0, g1}); end
    total++;
    if ({m_rx[0], m_rx[1]} !== 16'hC35A) begin bad++; $display("FAIL mode3_miso got=%h required=c35a", {m_rx[0], m_rx[1]}); end
    total++;
    if (txr_cnt - tc !== 2) begin bad++; $display("FAIL mode3_tx_ready got=%0d required=2", txr_cnt - tc); end
  endtask

  task automatic test_overrun();
    int rb, oc;
    logic [7:0] g;
    tx_mode = 1; tx_hold = 8'($urandom); rx_ready_i = 1'b0;
    oc = ovr_cnt;
    m_tx[0] = 8'h11; m_tx[1] = 8'h22;
    master_frame(1'b0, 1'b1, 2, 0, 1'b0);
    $display("overrun: rx_data=%h rx_valid=%b overruns=%0d", rx_data_o, rx_valid_o, ovr_cnt - oc);
    total++;
    if ({rx_valid_o, rx_data_o} !== {1'b1, 8'h11}) begin
      bad++;
      $display("FAIL overrun_hold got=%b/%h required=1/11", rx_valid_o, rx_data_o);
    end
    total++;
    if (ovr_cnt - oc !== 1) begin bad++; $display("FAIL overrun_pulses got=%0d required=1", ovr_cnt - oc); end
    total++;
    if ({m_rx[0], m_rx[1]} !== {tx_hold, tx_hold}) begin
      bad++;
      $display("FAIL overrun_miso got=%h required=%h", {m_rx[0], m_rx[1]}, {tx_hold, tx_hold});
    end
    rb = rx_got.size();
    rx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    g = (rx_got.size() > rb) ? rx_got[rb] : 8'hxx;
    total++;
    if ({rx_got.size() - rb == 1, g, rx_valid_o} !== {1'b1, 8'h11, 1'b0}) begin
      bad++;
      $display("FAIL overrun_drain got=%0d/%h/%b required=1/11/0", rx_got.size() - rb, g, rx_valid_o);
    end
  endtask

  task automatic test_underrun();
    int rb, tc, uc;
    logic [7:0] g;
    tx_mode = 0; rx_ready_i = 1'b1;
    rb = rx_got.size(); tc = txr_cnt; uc = und_cnt;
    m_tx[0] = 8'($urandom);
    master_frame(1'b1, 1'b0, 1, 0, 1'b0);
    g = (rx_got.size() > rb) ? rx_got[rb] : 8'hxx;
    $display("underrun: sent=%h rx=%h master_got=%h", m_tx[0], g, m_rx[0]);
    total++;
    if (m_rx[0] !== 8'hFF) begin bad++; $display("FAIL underrun_miso got=%h required=ff", m_rx[0]); end
    total++;
    if (und_cnt - uc !== 1) begin bad++; $display("FAIL underrun_pulses got=%0d required=1", und_cnt - uc); end
    total++;
    if (txr_cnt - tc !== 0) begin bad++; $display("FAIL underrun_tx_ready got=%0d required=0", txr_cnt - tc); end
    total++;
    if (g !== m_tx[0]) begin bad++; $display("FAIL underrun_rx_data got=%h required=%h", g, m_tx[0]); end
  endtask

  task automatic test_abort();
    int rb, oc;
    logic [7:0] g;
    tx_mode = 1; tx_hold = 8'h5A; rx_ready_i = 1'b1;
    rb = rx_got.size(); oc = ovr_cnt;
    m_tx[0] = 8'($urandom);
    master_frame(1'b0, 1'b0, 1, 5, 1'b0);
    total++;
    if ({rx_got.size() - rb == 0, ovr_cnt - oc == 0} !== 2'b11) begin
      bad++;
      $display("FAIL abort_no_byte got=%0d/%0d required=0/0", rx_got.size() - rb, ovr_cnt - oc);
    end
    rb = rx_got.size();
    m_tx[0] = 8'h81;
    master_frame(1'b0, 1'b0, 1, 0, 1'b0);
    g = (rx_got.size() > rb) ? rx_got[rb] : 8'hxx;
    $display("abort: next rx=%h master_got=%h", g, m_rx[0]);
    total++;
    if (g !== 8'h81) begin bad++; $display("FAIL abort_next_rx got=%h required=81", g); end
    total++;
    if (m_rx[0] !== 8'h5A) begin bad++; $display("FAIL abort_next_miso got=%h required=5a", m_rx[0]); end
  endtask

  task automatic test_midframe_reset();
    int rb;
    logic [7:0] g;
    tx_mode = 1; tx_hold = 8'($urandom); rx_ready_i = 1'b1;
    m_tx[0] = 8'($urandom);
    master_frame(1'b1, 1'b1, 1, 3, 1'b1);
    $display("midframe reset: outputs=%h", rst_snap);
    total++;
    if (rst_snap !== 15'h0) begin bad++; $display("FAIL midreset_outputs got=%h required=%h", rst_snap, 15'h0); end
    total++;
    if ({busy_o, rx_valid_o} !== 2'b00) begin bad++; $display("FAIL midreset_idle got=%b required=00", {busy_o, rx_valid_o}); end
    rb = rx_got.size();
    m_tx[0] = 8'($urandom);
    master_frame(1'b0, 1'b1, 1, 0, 1'b0);
    g = (rx_got.size() > rb) ? rx_got[rb] : 8'hxx;
    total++;
    if ({g, m_rx[0]} !== {m_tx[0], tx_hold}) begin
      bad++;
      $display("FAIL midreset_next got=%h/%h required=%h/%h", g, m_rx[0], m_tx[0], tx_hold);
    end
  endtask

  task automatic test_random_frames();
    int rb, tc, n;
    logic pol, pha;
    logic [7:0] exp_tx [4];
    logic [7:0] g;
    tx_mode = 2; rx_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pol = 1'($urandom); pha = 1'($urandom);
      n = $urandom_range(1, 3);
      for (int b = 0; b < n; b++) begin
        m_tx[b]   = 8'($urandom);
        exp_tx[b] = 8'($urandom);
        tx_arr[tx_len] = exp_tx[b];
        tx_len++;
      end
      rb = rx_got.size(); tc = txr_cnt;
      master_frame(pol, pha, n, 0, 1'b0);
      $display("random %0d: mode=%b%b bytes=%0d received=%0d", k, pol, pha, n, rx_got.size() - rb);
      total++;
      if (rx_got.size() - rb !== n) begin bad++; $display("FAIL rand_rx_count got=%0d required=%0d", rx_got.size() - rb, n); end
      total++;
      if (txr_cnt - tc !== n) begin bad++; $display("FAIL rand_tx_ready got=%0d required=%0d", txr_cnt - tc, n); end
      for (int b = 0; b < n; b++) begin
        g = (rx_got.size() > rb + b) ? rx_got[rb + b] : 8'hxx;
        total++;
        if (g !== m_tx[b]) begin bad++; $display("FAIL rand_rx_data[%0d] got=%h required=%h", b, g, m_tx[b]); end
        total++;
        if (m_rx[b] !== exp_tx[b]) begin bad++; $display("FAIL rand_miso[%0d] got=%h required=%h", b, m_rx[b], exp_tx[b]); end
      end
    end
  endtask

  initial begin
    rst_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; sck_i = 1'b0;
    ss_ni = 1'b1; mosi_i = 1'b0; rx_ready_i = 1'b1;
    test_reset();
    test_mode0();
    test_mode3_two_bytes();
    test_overrun();
    test_underrun();
    test_abort();
    test_midframe_reset();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
SPI slave endpoint that sits directly downstream of the simple_spi master, on the far end of its sck_o/mosi_o/miso_i/ss_o lines. It oversamples the SPI bus with the system clock, deserialises MOSI into bytes, and presents each byte on a valid/ready interface. It also serialises bytes from a valid/ready transmit interface onto MISO. The bench uses it as a loopback target for the master's clock-divider and FSM checks, and it is synthesizable as a real peripheral.

Parameters:
TX_DEFAULT, 8'hFF, byte shifted out on MISO when no transmit byte is available at a byte boundary.
SYNC_STAGES, 2, number of synchroniser flops on sck_i, ss_ni and mosi_i (legal range 2..3).

Ports:
clk_i  input  1  system clock; all logic on posedge.
rst_i  input  1  synchronous, active-low reset (0 = reset).
cpol_i  input  1  SPI clock polarity; sampled only while ss_ni is high.
cpha_i  input  1  SPI clock phase; sampled only while ss_ni is high.
sck_i  input  1  SPI clock from the master (asynchronous).
ss_ni  input  1  slave select, active-low (asynchronous).
mosi_i  input  1  master-out data.
miso_o  output  1  slave-out data, MSB first.
miso_oe_o  output  1  MISO output enable; 1 only while selected.
rx_data_o  output  8  last received byte.
rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
rx_ready_i  input  1  consumer accepts rx_data_o.
tx_data_i  input  8  next byte to send.
tx_valid_i  input  1  tx_data_i is valid.
tx_ready_o  output  1  slave takes tx_data_i this cycle.
overrun_o  output  1  one-cycle pulse: byte received while rx_valid_o was still 1.
underrun_o  output  1  one-cycle pulse: TX_DEFAULT loaded because tx_valid_i was 0.
busy_o  output  1  1 while in ACTIVE state.

Behaviour:
- Reset (rst_i = 0 at a clock edge): state = IDLE; bit counter = 0; shift registers = 0; rx_data_o = 8'h00; rx_valid_o, tx_ready_o, overrun_o, underrun_o, busy_o, miso_oe_o, miso_o all 0. Synchroniser flops reset to sck = cpol_i and ss = 1. Reset mid-frame aborts the frame with no rx_valid_o.
- Sync and edges: sck, ss and mosi pass through SYNC_STAGES flops. Edges are detected against one further registered copy.
  - Leading edge = sck leaving its idle level cpol_i; trailing edge = the opposite transition.
  - Sample edge = leading if cpha_i = 0, trailing if cpha_i = 1. Shift edge = the other one.
  - Supported sck frequency is at most clk_i/8.
- FSM, 3 states:
  - IDLE: miso_oe_o = 0. cpol_i/cpha_i are latched. On a synchronised ss falling edge, go to LOAD.
  - LOAD (1 cycle): load tx shift register from tx_data_i if tx_valid_i, with tx_ready_o = 1 for this cycle. Otherwise load TX_DEFAULT and pulse underrun_o. Bit counter = 0. Go to ACTIVE.
  - ACTIVE: busy_o = 1, miso_oe_o = 1.
    - cpha = 0: miso_o = shift-register MSB from LOAD onward; register shifts on each shift edge.
    - cpha = 1: miso_o updates to the next bit on each shift edge; the first leading edge drives the MSB.
    - Each sample edge shifts mosi into the rx shift register (MSB first) and increments the 3-bit counter.
    - When the counter wraps 7 to 0, the byte completes:
      - If rx_valid_o = 0, rx_data_o = assembled byte and rx_valid_o = 1 on the next cycle.
      - If rx_valid_o = 1, the byte is dropped, rx_data_o is unchanged, and overrun_o pulses.
      - The tx shift register reloads as in LOAD (same tx_ready_o/underrun_o rules), so multi-byte frames continue while ss stays low.
    - Synchronised ss rising edge: go to IDLE. A partial byte is discarded, the counter clears, and no rx_valid_o or overrun_o is produced.
- rx handshake: rx_valid_o clears the cycle after rx_valid_o && rx_ready_i. If a new byte completes in the same cycle as that transfer, the new byte is stored, rx_valid_o stays 1, and no overrun is flagged.
- tx handshake: tx_ready_o is asserted only in the reload cycles above and never twice per byte. tx_data_i is not sampled at other times.
- Byte-completion latency: rx_valid_o rises SYNC_STAGES+2 clk_i cycles after the 8th sample edge on the pin.

Test Plan:
- Mode 0 (cpol 0, cpha 0), master sends 8'hA5 at sck = clk/8, tx_data_i = 8'h3C held valid -> rx_data_o = 8'hA5 with rx_valid_o = 1; master receives 8'h3C; one tx_ready_o pulse; busy_o drops after ss rises.
- Mode 3 (cpol 1, cpha 1), two-byte frame 8'h12, 8'h34 with rx_ready_i = 1 -> two rx_valid_o pulses carrying 8'h12 then 8'h34; tx bytes 8'hC3, 8'h5A returned in order.
- Overrun: rx_ready_i = 0, master sends 8'h11 then 8'h22 -> rx_data_o stays 8'h11, exactly one overrun_o pulse.
- Underrun: tx_valid_i = 0, master sends one byte -> master receives 8'hFF, one underrun_o pulse in the LOAD cycle, tx_ready_o stays 0.
- Abort: ss raised after 5 bits -> no rx_valid_o; the next full byte 8'h81 is received correctly as 8'h81.
- Reset: rst_i = 0 for one cycle mid-byte -> all outputs 0 the next cycle, state IDLE; the following frame behaves normally.
